// File: rtl/aes_pkg.sv
// Shared AES definitions for the iterative cipher core.
// Contents:
//   - block, round-count and counter-width constants
//   - FSM state encoding
//   - S-box lookup, GF(2^8) xtime, and the round-key slice offset helper
package aes_pkg;

  localparam int unsigned AES_BLK = 128;
  localparam int unsigned NR_128  = 10;
  localparam int unsigned NR_192  = 12;
  localparam int unsigned NR_256  = 14;
  localparam int unsigned RC_W    = 4;

  typedef enum logic {
    StIdle = 1'b0,
    StRun  = 1'b1
  } aes_state_e;

  // Forward S-box. Byte 0x00 sits in the top byte, 0xff in the bottom byte.
  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    int unsigned idx;
    idx = 32'(b);
    return SBOX_TBL[2047 - 8 * idx -: 8];
  endfunction

  // Multiply by x in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Bit offset of round key r within the schedule bus.
  function automatic int unsigned rk_base(input int unsigned r);
    return AES_BLK * r;
  endfunction

endpackage

// File: rtl/aes_round.sv
// One combinational AES encryption round.
// Ports:
//   state_i     [0:127]  round input state (FIPS-197 byte order, bit 0 = MSB of byte 0)
//   rk_i        [0:127]  round key
//   final_rnd_i          1 = last round, MixColumns bypassed
//   state_o     [0:127]  add_round_key(MixColumns(shift_rows(sub_bytes(state_i))), rk_i)
module aes_round
  import aes_pkg::*;
(
  input  logic [0:AES_BLK-1] state_i,
  input  logic [0:AES_BLK-1] rk_i,
  input  logic               final_rnd_i,
  output logic [0:AES_BLK-1] state_o
);

  logic [7:0] sb [16];
  logic [7:0] sr [16];
  logic [7:0] mc [16];

  for (genvar i = 0; i < 16; i++) begin : g_sub
    assign sb[i] = sbox(state_i[8*i +: 8]);
  end

  // Byte i is row i%4 of column i/4; row r rotates left by r columns.
  for (genvar c = 0; c < 4; c++) begin : g_shift_col
    for (genvar r = 0; r < 4; r++) begin : g_shift_row
      assign sr[4*c+r] = sb[4*((c+r)%4)+r];
    end
  end

  for (genvar c = 0; c < 4; c++) begin : g_mix
    assign mc[4*c+0] = xtime(sr[4*c+0]) ^ xtime(sr[4*c+1]) ^ sr[4*c+1] ^ sr[4*c+2] ^ sr[4*c+3];
    assign mc[4*c+1] = sr[4*c+0] ^ xtime(sr[4*c+1]) ^ xtime(sr[4*c+2]) ^ sr[4*c+2] ^ sr[4*c+3];
    assign mc[4*c+2] = sr[4*c+0] ^ sr[4*c+1] ^ xtime(sr[4*c+2]) ^ xtime(sr[4*c+3]) ^ sr[4*c+3];
    assign mc[4*c+3] = xtime(sr[4*c+0]) ^ sr[4*c+0] ^ sr[4*c+1] ^ sr[4*c+2] ^ xtime(sr[4*c+3]);
  end

  for (genvar i = 0; i < 16; i++) begin : g_ark
    assign state_o[8*i +: 8] = (final_rnd_i ? sr[i] : mc[i]) ^ rk_i[8*i +: 8];
  end

endmodule

// File: rtl/aes_cipher_seq.sv
// Iterative AES encryption core, one round per clock, NR = 10/12/14.
// Ports:
//   clk        rising-edge clock
//   reset      synchronous active-high reset
//   start      begin encrypting `in` (ignored while busy)
//   in         [0:127]  plaintext, sampled only on accepted start
//   words      [0:NW-1] full round-key schedule, round key r at words[128*r +: 128];
//                       must stay stable from start acceptance through done
//   out        [0:127]  state / ciphertext register
//   busy       block in progress
//   done       one-cycle pulse when ciphertext is written
//   out_valid  held from done until the next accepted start or reset
module aes_cipher_seq
  import aes_pkg::*;
#(
  parameter int unsigned NR = NR_128,
  parameter int unsigned NW = AES_BLK * (NR + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [0:AES_BLK-1] in,
  input  logic [0:NW-1]      words,
  output logic [0:AES_BLK-1] out,
  output logic               busy,
  output logic               done,
  output logic               out_valid
);

  if (!(NR == NR_128 || NR == NR_192 || NR == NR_256)) begin : g_bad_nr
    $error("aes_cipher_seq: NR must be 10, 12 or 14");
  end
  if (NW != AES_BLK * (NR + 1)) begin : g_bad_nw
    $error("aes_cipher_seq: NW is derived from NR and must not be overridden");
  end

  localparam logic [RC_W-1:0] NrLast = RC_W'(NR);

  aes_state_e         state_q, state_d;
  logic [RC_W-1:0]    rc_q, rc_d;
  logic [0:AES_BLK-1] out_q, out_d;
  logic               done_q, done_d;
  logic               valid_q, valid_d;

  logic [0:AES_BLK-1] rk [NR+1];
  logic [RC_W-1:0]    key_idx;
  logic [0:AES_BLK-1] rk_sel;
  logic [0:AES_BLK-1] rnd_out;
  logic               final_rnd;

  for (genvar r = 0; r <= NR; r++) begin : g_rk
    assign rk[r] = words[rk_base(r) +: AES_BLK];
  end

  // Key 0 while idle (start whitening), otherwise the running round number. rc_q never
  // leaves 1..NR in RUN, so the index is always within the schedule.
  assign key_idx   = (state_q == StRun) ? rc_q : '0;
  assign rk_sel    = rk[key_idx];
  assign final_rnd = (state_q == StRun) && (rc_q == NrLast);

  aes_round u_round (
    .state_i     (out_q),
    .rk_i        (rk_sel),
    .final_rnd_i (final_rnd),
    .state_o     (rnd_out)
  );

  always_comb begin
    state_d = state_q;
    rc_d    = rc_q;
    out_d   = out_q;
    done_d  = 1'b0;
    valid_d = valid_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          out_d   = in ^ rk_sel;
          rc_d    = RC_W'(1);
          valid_d = 1'b0;
          state_d = StRun;
        end
      end
      StRun: begin
        out_d = rnd_out;
        if (final_rnd) begin
          rc_d    = '0;
          done_d  = 1'b1;
          valid_d = 1'b1;
          state_d = StIdle;
        end else begin
          rc_d = rc_q + RC_W'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      rc_q    <= '0;
      out_q   <= '0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rc_q    <= rc_d;
      out_q   <= out_d;
      done_q  <= done_d;
      valid_q <= valid_d;
    end
  end

  assign out       = out_q;
  assign busy      = (state_q == StRun);
  assign done      = done_q;
  assign out_valid = valid_q;

endmodule
